elastic_reg_pipe: RTL and testbench

ELASTIC_REG_PIPE -- requirements
Module: elastic_reg_pipe

---
 rtl/elastic_reg_pipe_pkg.sv | 13 +
 rtl/elastic_reg_stage.sv | 57 +++++
 rtl/elastic_reg_pipe.sv | 76 +++++++
 tb/tb_elastic_reg_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/elastic_reg_pipe_pkg.sv
// rtl/elastic_reg_pipe_pkg.sv - shared defaults and count-width helper for the elastic register pipe
package elastic_reg_pipe_pkg;

    localparam int          DEFAULT_WIDTH = 8;
    localparam int          DEFAULT_DEPTH = 2;
    localparam logic [7:0]  DEFAULT_INIT  = 8'hDE;

    // Width of the occupancy counter; must represent 0..depth inclusive
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_reg_stage.sv
// rtl/elastic_reg_stage.sv - one elastic stage: data register, full flag, bubble-collapsing ready
module elastic_reg_stage
    import elastic_reg_pipe_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEFAULT_INIT)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_next_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic             load;

    // An empty stage always accepts; a full one accepts only if it drains this cycle
    assign ready_o = !full_q || ready_next_i;
    assign load    = valid_i && ready_o;

    // Occupancy next state: a load wins, otherwise a full stage empties when downstream takes it
    always_comb begin
        full_d = full_q;
        if (load) begin
            full_d = 1'b1;
        end else if (ready_next_i) begin
            full_d = 1'b0;
        end
    end

    // Data only moves on a load; an emptied stage keeps its stale word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= INIT;
        end else if (clr_i) begin
            full_q <= 1'b0;
            data_q <= INIT;
        end else begin
            full_q <= full_d;
            if (load) begin
                data_q <= data_i;
            end
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/elastic_reg_pipe.sv
// rtl/elastic_reg_pipe.sv - DEPTH-stage elastic register pipeline with flush and occupancy count
module elastic_reg_pipe
    import elastic_reg_pipe_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter int               DEPTH = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEFAULT_INIT)
) (
    input  logic                            CLK,
    input  logic                            ASYNCRESETN,
    input  logic                            CLR,
    input  logic                            I_valid,
    output logic                            I_ready,
    input  logic [WIDTH-1:0]                I,
    output logic                            O_valid,
    input  logic                            O_ready,
    output logic [WIDTH-1:0]                O,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] full_w;
    logic [DEPTH:0]   ready_w;
    logic [WIDTH-1:0] data_w [DEPTH];
    logic [CW-1:0]    count_w;

    // The ready chain terminates at the downstream consumer
    assign ready_w[DEPTH] = O_ready;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            logic             src_valid;
            logic [WIDTH-1:0] src_data;

            if (k == 0) begin : g_head
                assign src_valid = I_valid;
                assign src_data  = I;
            end else begin : g_body
                assign src_valid = full_w[k-1];
                assign src_data  = data_w[k-1];
            end

            elastic_reg_stage #(
                .WIDTH (WIDTH),
                .INIT  (INIT)
            ) u_stage (
                .clk_i        (CLK),
                .rst_ni       (ASYNCRESETN),
                .clr_i        (CLR),
                .valid_i      (src_valid),
                .data_i       (src_data),
                .ready_next_i (ready_w[k+1]),
                .ready_o      (ready_w[k]),
                .full_o       (full_w[k]),
                .data_o       (data_w[k])
            );
        end
    endgenerate

    // Occupancy is the number of full stages
    always_comb begin
        count_w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_w = count_w + CW'(full_w[i]);
        end
    end

    // A flush cycle refuses new input so nothing is silently swallowed
    assign I_ready = ready_w[0] && !CLR;
    assign O_valid = full_w[DEPTH-1];
    assign O       = data_w[DEPTH-1];
    assign count   = count_w;

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// tb/tb_elastic_reg_pipe.sv - scoreboard bench for elastic_reg_pipe (WIDTH=8, DEPTH=2)
module tb_elastic_reg_pipe;

    localparam int DEPTH = 2;

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       i_valid;
    logic       i_ready;
    logic [7:0] i_data;
    logic       o_valid;
    logic       o_ready;
    logic [7:0] o_data;
    logic [1:0] count;

    int   total;
    int   bad;
    int   cyc;
    int   pops;
    exp_t q[$];

    elastic_reg_pipe #(
        .WIDTH (8),
        .DEPTH (DEPTH),
        .INIT  (8'hDE)
    ) dut (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .CLR         (clr),
        .I_valid     (i_valid),
        .I_ready     (i_ready),
        .I           (i_data),
        .O_valid     (o_valid),
        .O_ready     (o_ready),
        .O           (o_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completed output handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && !clr && o_valid && o_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 32'(o_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                pops++;
                check("out_data", 32'(o_data), 32'(e.d));
                if (e.due >= 0) check("out_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Present one word, wait (bounded) for acceptance, record the expectation
    task automatic drive(input logic [7:0] d, input bit timed);
        exp_t e;
        bit   done;
        done    = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        for (int t = 0; t < 20 && !done; t++) begin
            #1;
            if (i_ready) begin
                e.d   = d;
                e.due = timed ? cyc + DEPTH : -1;
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        pops    = 0;
        rst_n   = 1'b1;
        clr     = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b0;

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("rst_O", 32'(o_data), 32'hDE);
        check("rst_O_valid", 32'(o_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_I_ready", 32'(i_ready), 32'd1);
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming with latency DEPTH
        o_ready = 1'b1;
        drive(8'h01, 1'b1);
        drive(8'h02, 1'b1);
        drive(8'h03, 1'b1);
        idle(4);
        check("stream_drained", 32'(q.size()), 32'd0);

        // Backpressure: fill, third word held off, then release
        o_ready = 1'b0;
        drive(8'h10, 1'b0);
        drive(8'h11, 1'b0);
        check("bp_count", 32'(count), 32'd2);
        i_valid = 1'b1;
        i_data  = 8'h12;
        #1;
        check("bp_I_ready", 32'(i_ready), 32'd0);
        idle(2);
        check("bp_hold_O", 32'(o_data), 32'h10);
        check("bp_hold_count", 32'(count), 32'd2);
        o_ready = 1'b1;
        drive(8'h12, 1'b0);
        idle(4);
        check("bp_drained", 32'(q.size()), 32'd0);

        // Full with simultaneous retire and enter
        o_ready = 1'b0;
        drive(8'h1E, 1'b0);
        drive(8'h1F, 1'b0);
        check("full_count_before", 32'(count), 32'd2);
        o_ready = 1'b1;
        drive(8'h20, 1'b0);
        o_ready = 1'b0;
        check("full_count_after", 32'(count), 32'd2);
        check("full_new_head", 32'(o_data), 32'h1F);

        // Flush with a simultaneous input word
        clr     = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h55;
        #1;
        check("clr_I_ready", 32'(i_ready), 32'd0);
        @(posedge clk); #1;
        clr     = 1'b0;
        i_valid = 1'b0;
        q.delete();
        check("clr_count", 32'(count), 32'd0);
        check("clr_O_valid", 32'(o_valid), 32'd0);
        check("clr_O", 32'(o_data), 32'hDE);
        o_ready = 1'b1;
        idle(3);

        // Bubble collapse under backpressure
        o_ready = 1'b0;
        drive(8'hAA, 1'b0);
        idle(1);
        drive(8'hBB, 1'b0);
        check("bubble_count", 32'(count), 32'd2);
        check("bubble_O", 32'(o_data), 32'hAA);
        check("bubble_O_valid", 32'(o_valid), 32'd1);
        o_ready = 1'b1;
        idle(4);
        check("bubble_drained", 32'(q.size()), 32'd0);

        // Reset in the middle of a transfer discards in-flight data
        o_ready = 1'b0;
        drive(8'h77, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_O_valid", 32'(o_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_O", 32'(o_data), 32'hDE);
        check("midrst_I_ready", 32'(i_ready), 32'd1);
        q.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        o_ready = 1'b1;
        idle(3);

        check("final_queue", 32'(q.size()), 32'd0);
        check("final_pops", 32'(pops), 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
